ack_bloom_filter: RTL

//  - Downstream of the TCP header-parse stage. Consumes its per-packet hash request
//    (bloom_wr, two indices, 96-bit tuple, ACK flag).
//  - Data segment (pkt_is_ack=0): inserts the expected-ACK signature by setting 2 bits.
//    ACK segment: tests the same 2 bits and reports hit/miss with the tuple.
//  - Bit array is on-chip, word-organised RAM. Keeps insert/lookup/hit/drop statistics.

---
 rtl/ack_bloom_filter_pkg.sv | 8 +
 rtl/ack_bloom_filter_ram.sv | 17 +
 rtl/ack_bloom_filter.sv | 105 ++++++++++
 3 files changed

// File: rtl/ack_bloom_filter_pkg.sv
// ack_bloom_filter_pkg: shared FSM states, default word-select width and RAM address-width helper
package ack_bloom_filter_pkg;
  typedef enum logic [2:0] {CLEAR, IDLE, RD0, MOD0, RD1, MOD1} state_t;
  localparam int WORD_SEL = 5;
  function automatic int addr_w(input int hash_bits, input int word_sel);
    return hash_bits - word_sel;
  endfunction
endpackage

// File: rtl/ack_bloom_filter_ram.sv
// bloom_bit_ram: single-port synchronous RAM (clk, we, addr, wdata -> rdata, 1-cycle read latency, read-first)
module bloom_bit_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ack_bloom_filter.sv
// ack_bloom_filter: two-bit Bloom filter for expected ACKs (clk, reset, bloom_wr/index_0/index_1/wire_tuple/pkt_is_ack/clear_req in; bloom_rdy, match_*, num_* out)
module ack_bloom_filter #(
  parameter int HASH_BITS = 19,
  parameter int WORD_SEL  = ack_bloom_filter_pkg::WORD_SEL,
  parameter int TUPLE_W   = 96
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bloom_wr,
  output logic                 bloom_rdy,
  input  logic [HASH_BITS-1:0] index_0,
  input  logic [HASH_BITS-1:0] index_1,
  input  logic [TUPLE_W-1:0]   wire_tuple,
  input  logic                 pkt_is_ack,
  input  logic                 clear_req,
  output logic                 match_valid,
  output logic                 match_hit,
  output logic [TUPLE_W-1:0]   match_tuple,
  output logic [31:0]          num_inserts,
  output logic [31:0]          num_lookups,
  output logic [31:0]          num_hits,
  output logic [31:0]          num_dropped
);
  import ack_bloom_filter_pkg::*;
  localparam int ADDR_W = addr_w(HASH_BITS, WORD_SEL);
  localparam int WORD_W = 1 << WORD_SEL;
  localparam int DEPTH  = 1 << ADDR_W;
  state_t               state;
  logic [HASH_BITS-1:0] idx0, idx1;
  logic [TUPLE_W-1:0]   tuple;
  logic                 is_ack, bit0, clear_pending, first, hit;
  logic [ADDR_W-1:0]    clr_addr, addr;
  logic [WORD_SEL-1:0]  bsel;
  logic                 we;
  logic [WORD_W-1:0]    wdata, rdata;
  assign bloom_rdy = state == IDLE;
  // RD0/MOD0 work on index 0, RD1/MOD1 on index 1; MOD writes back the word read in RD
  always_comb begin
    first = state == RD0 || state == MOD0;
    bsel  = first ? idx0[WORD_SEL-1:0] : idx1[WORD_SEL-1:0];
    addr  = state == CLEAR ? clr_addr : first ? idx0[HASH_BITS-1:WORD_SEL] : idx1[HASH_BITS-1:WORD_SEL];
    we    = state == CLEAR || (!is_ack && (state == MOD0 || state == MOD1));
    wdata = state == CLEAR ? '0 : rdata | (WORD_W'(1) << bsel);
    hit   = bit0 & rdata[bsel];
  end
  bloom_bit_ram #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      clr_addr      <= '0;
      clear_pending <= 1'b0;
      idx0          <= '0;
      idx1          <= '0;
      tuple         <= '0;
      is_ack        <= 1'b0;
      bit0          <= 1'b0;
      match_valid   <= 1'b0;
      match_hit     <= 1'b0;
      match_tuple   <= '0;
      num_inserts   <= '0;
      num_lookups   <= '0;
      num_hits      <= '0;
      num_dropped   <= '0;
    end else begin
      match_valid <= 1'b0;
      if (bloom_wr && state != IDLE) num_dropped <= num_dropped + 32'd1;
      // a request in the same IDLE cycle beats a pending clear, which then waits for the next idle cycle
      clear_pending <= clear_req || (clear_pending && !(state == IDLE && !bloom_wr));
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) state <= IDLE;
        end
        IDLE: begin
          if (bloom_wr) begin
            idx0   <= index_0;
            idx1   <= index_1;
            tuple  <= wire_tuple;
            is_ack <= pkt_is_ack;
            state  <= RD0;
          end else if (clear_pending) state <= CLEAR;
        end
        RD0: state <= MOD0;
        MOD0: begin
          bit0  <= rdata[bsel];
          state <= RD1;
        end
        RD1: state <= MOD1;
        MOD1: begin
          state <= IDLE;
          if (is_ack) begin
            match_valid <= 1'b1;
            match_hit   <= hit;
            match_tuple <= tuple;
            num_lookups <= num_lookups + 32'd1;
            if (hit) num_hits <= num_hits + 32'd1;
          end else num_inserts <= num_inserts + 32'd1;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
